// File: rtl/video_timing_pkg.sv
// Shared types and default timing constants for the video timing generator.
package video_timing_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_VSYNC,
        ST_VBACK,
        ST_ACTIVE,
        ST_VFRONT
    } vtg_state_t;

    localparam int VTG_CNT_W        = 16;
    localparam int VTG_FRAME_WIDTH  = 640;
    localparam int VTG_FRAME_HEIGHT = 512;
    localparam int VTG_H_BLANK      = 160;
    localparam int VTG_V_SYNC       = 2;
    localparam int VTG_V_BACK       = 8;
    localparam int VTG_V_FRONT      = 2;
    // 256-bit AXI word carries 16 pixels of 16 bits
    localparam int VTG_PACK_RATIO   = 16;

endpackage

// File: rtl/vtg_hv_counter.sv
// Horizontal/vertical position counter pair; h wraps every H_TOTAL clocks while running.
module vtg_hv_counter
    import video_timing_pkg::*;
#(
    parameter int H_TOTAL = VTG_FRAME_WIDTH + VTG_H_BLANK
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 run,
    input  logic                 v_clear,
    output logic [VTG_CNT_W-1:0] h_cnt,
    output logic [VTG_CNT_W-1:0] v_cnt,
    output logic                 line_wrap
);

    localparam logic [VTG_CNT_W-1:0] H_LAST = VTG_CNT_W'(H_TOTAL - 1);

    assign line_wrap = (h_cnt == H_LAST);

    // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (run) begin
            if (line_wrap) begin
                h_cnt <= '0;
                v_cnt <= v_clear ? '0 : v_cnt + 1'b1;
            end else begin
                h_cnt <= h_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/video_timing_gen.sv
// Frame timing FSM producing VSYNC, data enable and pixel/line indices.
// Optional build macro VTG_EXT_TRIG_EN gates each frame start on an external trigger.
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int FRAME_WIDTH  = VTG_FRAME_WIDTH,
    parameter int FRAME_HEIGHT = VTG_FRAME_HEIGHT,
    parameter int H_BLANK      = VTG_H_BLANK,
    parameter int V_SYNC       = VTG_V_SYNC,
    parameter int V_BACK       = VTG_V_BACK,
    parameter int V_FRONT      = VTG_V_FRONT
) (
    input  logic                 rd_clk,
    input  logic                 rd_rst,
    input  logic                 i_enable,
`ifdef VTG_EXT_TRIG_EN
    input  logic                 i_frame_trig,
`endif
    output logic                 o_vs,
    output logic                 o_de,
    output logic [VTG_CNT_W-1:0] o_pix_cnt,
    output logic [VTG_CNT_W-1:0] o_line_cnt,
    output logic                 o_frame_done,
    output logic [VTG_CNT_W-1:0] o_frame_cnt,
    output logic                 o_busy
);

    localparam int H_TOTAL = FRAME_WIDTH + H_BLANK;
    localparam logic [VTG_CNT_W-1:0] H_LAST    = VTG_CNT_W'(H_TOTAL - 1);
    localparam logic [VTG_CNT_W-1:0] W_ACTIVE  = VTG_CNT_W'(FRAME_WIDTH);
    localparam logic [VTG_CNT_W-1:0] VS_LAST   = VTG_CNT_W'(V_SYNC - 1);
    localparam logic [VTG_CNT_W-1:0] VB_LAST   = VTG_CNT_W'(V_BACK - 1);
    localparam logic [VTG_CNT_W-1:0] ACT_LAST  = VTG_CNT_W'(FRAME_HEIGHT - 1);
    localparam logic [VTG_CNT_W-1:0] VF_LAST   = VTG_CNT_W'(V_FRONT - 1);

    if (FRAME_WIDTH % VTG_PACK_RATIO != 0) begin : g_bad_width
        $error("video_timing_gen: FRAME_WIDTH must be a multiple of 16");
    end
    if (H_BLANK < 1 || V_SYNC < 1 || V_BACK < 1 || V_FRONT < 1) begin : g_bad_blank
        $error("video_timing_gen: blanking parameters must each be at least 1");
    end

    vtg_state_t           state, state_nxt;
    logic [VTG_CNT_W-1:0] h_cnt, v_cnt, h_nxt, v_nxt;
    logic                 line_wrap, leave, go, de_nxt, done_nxt;

    vtg_hv_counter #(.H_TOTAL(H_TOTAL)) u_hv (
        .clk       (rd_clk),
        .rst       (rd_rst),
        .clear     (state == ST_IDLE),
        .run       (state != ST_IDLE),
        .v_clear   (leave),
        .h_cnt     (h_cnt),
        .v_cnt     (v_cnt),
        .line_wrap (line_wrap)
    );

`ifdef VTG_EXT_TRIG_EN
    logic trig_pend;

    // A pending trigger is consumed by the VSYNC entry it enables.
    always_ff @(posedge rd_clk) begin
        if (rd_rst)
            trig_pend <= 1'b0;
        else if (state_nxt == ST_VSYNC && state != ST_VSYNC)
            trig_pend <= 1'b0;
        else if (i_frame_trig)
            trig_pend <= 1'b1;
    end

    assign go = i_enable && (trig_pend || i_frame_trig);
`else
    assign go = i_enable;
`endif

    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    always_comb begin
        state_nxt = state;
        leave     = 1'b0;
        case (state)
            ST_IDLE:   if (go) state_nxt = ST_VSYNC;
            ST_VSYNC:  if (line_wrap && v_cnt == VS_LAST) begin
                           state_nxt = ST_VBACK;
                           leave     = 1'b1;
                       end
            ST_VBACK:  if (line_wrap && v_cnt == VB_LAST) begin
                           state_nxt = ST_ACTIVE;
                           leave     = 1'b1;
                       end
            ST_ACTIVE: if (line_wrap && v_cnt == ACT_LAST) begin
                           state_nxt = ST_VFRONT;
                           leave     = 1'b1;
                       end
            ST_VFRONT: if (line_wrap && v_cnt == VF_LAST) begin
                           state_nxt = go ? ST_VSYNC : ST_IDLE;
                           leave     = 1'b1;
                       end
            default:   state_nxt = ST_IDLE;
        endcase

        // Counter values after this edge, so registered outputs line up with state.
        h_nxt    = (state == ST_IDLE || line_wrap) ? '0 : h_cnt + 1'b1;
        v_nxt    = (state == ST_IDLE) ? '0 :
                   line_wrap ? (leave ? '0 : v_cnt + 1'b1) : v_cnt;
        de_nxt   = (state_nxt == ST_ACTIVE) && (h_nxt < W_ACTIVE);
        done_nxt = (state_nxt == ST_VFRONT) && (h_nxt == H_LAST) && (v_nxt == VF_LAST);
    end

    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            state        <= ST_IDLE;
            o_vs         <= 1'b0;
            o_de         <= 1'b0;
            o_pix_cnt    <= '0;
            o_line_cnt   <= '0;
            o_frame_done <= 1'b0;
            o_frame_cnt  <= '0;
            o_busy       <= 1'b0;
        end else begin
            state        <= state_nxt;
            o_vs         <= (state_nxt == ST_VSYNC);
            o_de         <= de_nxt;
            o_pix_cnt    <= de_nxt ? h_nxt : '0;
            o_line_cnt   <= de_nxt ? v_nxt : '0;
            o_frame_done <= done_nxt;
            o_busy       <= (state_nxt != ST_IDLE);
            if (done_nxt)
                o_frame_cnt <= o_frame_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen with a per-cycle expected-output scoreboard.
// Define VTG_EXT_TRIG_EN for both RTL and bench to exercise the trigger scenario.
module tb_video_timing_gen;

    localparam int FW = 16, FH = 3, HB = 4, VS = 1, VB = 2, VF = 1;
    localparam int HT    = FW + HB;
    localparam int FRAME = (VS + VB + FH + VF) * HT;   // 140 clocks
    localparam int IDLE_K = FRAME;                     // model index meaning "idle"

    typedef struct packed {
        logic        vs;
        logic        de;
        logic        done;
        logic        busy;
        logic [15:0] pix;
        logic [15:0] line;
    } obs_t;

    logic        rd_clk = 1'b0;
    logic        rd_rst = 1'b1;
    logic        i_enable = 1'b0;
    logic        o_vs, o_de, o_frame_done, o_busy;
    logic [15:0] o_pix_cnt, o_line_cnt, o_frame_cnt;
`ifdef VTG_EXT_TRIG_EN
    logic        i_frame_trig = 1'b0;
`endif

    int   checks = 0;
    int   errors = 0;
    obs_t sb_q[$];

    always #5 rd_clk = ~rd_clk;

    video_timing_gen #(
        .FRAME_WIDTH (FW), .FRAME_HEIGHT(FH), .H_BLANK(HB),
        .V_SYNC      (VS), .V_BACK      (VB), .V_FRONT(VF)
    ) dut (
        .rd_clk       (rd_clk),
        .rd_rst       (rd_rst),
        .i_enable     (i_enable),
`ifdef VTG_EXT_TRIG_EN
        .i_frame_trig (i_frame_trig),
`endif
        .o_vs         (o_vs),
        .o_de         (o_de),
        .o_pix_cnt    (o_pix_cnt),
        .o_line_cnt   (o_line_cnt),
        .o_frame_done (o_frame_done),
        .o_frame_cnt  (o_frame_cnt),
        .o_busy       (o_busy)
    );

    // Expected outputs k clocks after the edge that leaves IDLE; k >= FRAME means idle.
    function automatic obs_t model(int k);
        obs_t e;
        int   ln, h, act_ln;
        e = '0;
        if (k >= FRAME) return e;
        ln     = k / HT;
        h      = k % HT;
        act_ln = ln - (VS + VB);
        e.vs   = (ln < VS);
        e.de   = (act_ln >= 0) && (act_ln < FH) && (h < FW);
        e.pix  = e.de ? 16'(h) : 16'd0;
        e.line = e.de ? 16'(act_ln) : 16'd0;
        e.done = (k == FRAME - 1);
        e.busy = 1'b1;
        return e;
    endfunction

    function automatic obs_t observe();
        obs_t o;
        o.vs = o_vs; o.de = o_de; o.done = o_frame_done; o.busy = o_busy;
        o.pix = o_pix_cnt; o.line = o_line_cnt;
        return o;
    endfunction

    task automatic push_range(input int first, input int last);
        for (int k = first; k <= last; k++) sb_q.push_back(model(k));
    endtask

    task automatic push_idle(input int n);
        for (int i = 0; i < n; i++) sb_q.push_back(model(IDLE_K));
    endtask

    task automatic check_obs(input string tag, input obs_t got, input obs_t exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic check16(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Pop one expectation per clock, sampled on the falling edge.
    task automatic drain(input string tag, input int n);
        obs_t exp;
        for (int i = 0; i < n; i++) begin
            @(negedge rd_clk);
            checks++;
            assert (sb_q.size() > 0) else begin
                errors++;
                $error("FAIL %s_queue observed=empty expected=entry", tag);
                continue;
            end
            exp = sb_q.pop_front();
            check_obs(tag, observe(), exp);
        end
    endtask

    task automatic do_reset();
        @(negedge rd_clk);
        rd_rst   = 1'b1;
        i_enable = 1'b0;
        repeat (2) @(negedge rd_clk);
        check_obs("in_reset", observe(), model(IDLE_K));
        check16("in_reset_fcnt", o_frame_cnt, 16'd0);
        rd_rst = 1'b0;
    endtask

    initial begin
        // Reset state.
        do_reset();
        push_idle(4);
        drain("idle_after_reset", 4);

        // Basic frame with enable held: full frame, then the next VSYNC begins.
        i_enable = 1'b1;
        push_range(0, FRAME - 1);
        push_range(0, HT - 1);
        drain("basic", FRAME);
        check16("basic_fcnt", o_frame_cnt, 16'd1);
        drain("basic_next_vs", HT);

        // Enable dropped during active line 1: frame completes, then idle.
        do_reset();
        i_enable = 1'b1;
        push_range(0, FRAME - 1);
        push_idle(40);
        drain("disable", 85);
        i_enable = 1'b0;
        drain("disable", FRAME - 85 + 40);
        check16("disable_fcnt", o_frame_cnt, 16'd1);

        // Reset during active line 2: immediate abort, no frame_done afterwards.
        do_reset();
        i_enable = 1'b1;
        push_range(0, 104);
        drain("pre_abort", 105);
        rd_rst   = 1'b1;
        i_enable = 1'b0;
        @(negedge rd_clk);
        check_obs("abort", observe(), model(IDLE_K));
        check16("abort_fcnt", o_frame_cnt, 16'd0);
        rd_rst = 1'b0;
        push_idle(FRAME + 10);
        drain("post_abort", FRAME + 10);

        // Frame counter wrap from 16'hFFFF.
        force dut.o_frame_cnt = 16'hFFFF;
        @(negedge rd_clk);
        release dut.o_frame_cnt;
        @(negedge rd_clk);
        check16("wrap_preset", o_frame_cnt, 16'hFFFF);
        i_enable = 1'b1;
        push_range(0, FRAME - 1);
        push_idle(20);
        drain("wrap", 80);
        i_enable = 1'b0;
        drain("wrap", FRAME - 80 + 20);
        check16("wrap_fcnt", o_frame_cnt, 16'd0);

`ifdef VTG_EXT_TRIG_EN
        // Enable alone does not start; one trigger yields exactly one frame.
        do_reset();
        i_enable = 1'b1;
        push_idle(30);
        drain("trig_wait", 30);
        i_frame_trig = 1'b1;
        push_range(0, FRAME - 1);
        push_idle(40);
        drain("trig_frame", 1);
        i_frame_trig = 1'b0;
        drain("trig_frame", FRAME - 1 + 40);
        check16("trig_fcnt", o_frame_cnt, 16'd1);
        i_enable = 1'b0;
`endif

        checks++;
        assert (sb_q.size() == 0) else begin
            errors++;
            $error("FAIL sb_leftover observed=%0d expected=0", sb_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/video_timing_gen.md
VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

Interface
REQ-001 SHALL have parameter FRAME_WIDTH, default 640: active pixels per line.
REQ-002 SHALL have parameter FRAME_HEIGHT, default 512: active lines per frame.
REQ-003 SHALL have parameter H_BLANK, default 160: blank clocks per line, minimum 1.
REQ-004 SHALL have parameters V_SYNC, V_BACK, V_FRONT, defaults 2, 8, 2: line counts of the sync, back-porch and front-porch regions, each minimum 1.
REQ-005 SHALL have ports, clock and reset first:
  rd_clk  in  1  pixel clock; single clock domain
  rd_rst  in  1  reset; synchronous, active-high
  i_enable  in  1  level; start or continue frame generation
  o_vs  out  1  VSYNC, active high
  o_de  out  1  data enable, active high
  o_pix_cnt  out  16  pixel index within the active line
  o_line_cnt  out  16  active line index
  o_frame_done  out  1  one-cycle pulse at the end of each frame
  o_frame_cnt  out  16  completed frames, wraps
  o_busy  out  1  FSM not in IDLE

Function
REQ-006 SHALL define H_TOTAL = FRAME_WIDTH + H_BLANK; the horizontal counter h_cnt SHALL run 0..H_TOTAL-1 and wrap every clock outside IDLE.
REQ-007 SHALL implement FSM states IDLE, VSYNC, VBACK, ACTIVE, VFRONT, with a line counter v_cnt that clears on each state entry.
REQ-008 IDLE -> VSYNC SHALL occur on the first clock with i_enable=1; h_cnt=0 and v_cnt=0 on the following clock.
REQ-009 Transitions out of non-IDLE states SHALL occur only at h_cnt wrap (h_cnt=H_TOTAL-1):
  - VSYNC -> VBACK after V_SYNC lines.
  - VBACK -> ACTIVE after V_BACK lines.
  - ACTIVE -> VFRONT after FRAME_HEIGHT lines.
  - VFRONT -> VSYNC after V_FRONT lines if i_enable=1, else -> IDLE.
REQ-010 o_vs SHALL be 1 exactly while the state is VSYNC, registered, with 0 cycles of skew relative to the state.
REQ-011 o_de SHALL be 1 while the state is ACTIVE and h_cnt < FRAME_WIDTH, giving FRAME_WIDTH consecutive clocks per line, registered.
REQ-012 o_pix_cnt SHALL equal h_cnt and o_line_cnt SHALL equal v_cnt while o_de=1; both SHALL be 0 otherwise.
REQ-013 o_frame_done SHALL pulse for one clock on the last clock of VFRONT; o_frame_cnt SHALL increment on the same edge, with modulo 2^16 wrap.
REQ-014 Deasserting i_enable mid-frame SHALL NOT truncate the frame; the full frame SHALL complete, then the FSM enters IDLE.
REQ-015 Per frame, the block SHALL produce exactly FRAME_HEIGHT*FRAME_WIDTH o_de clocks, so that the downstream FIFO unpacker consumes whole AXI words.
REQ-016 FRAME_WIDTH SHALL be a multiple of 16 (256-bit / 16-bit pack ratio); the block SHALL issue an elaboration error otherwise.
REQ-017 V_BACK*H_TOTAL SHALL provide the DMA prefetch window after the VS rising edge; the integrator SHALL size V_BACK so this window is at least 64 AXI beats of latency.

Reset
REQ-018 On rd_clk with rd_rst=1, the block SHALL set the state to IDLE and h_cnt, v_cnt and o_frame_cnt to 0.
REQ-019 During reset, o_vs, o_de, o_frame_done and o_busy SHALL be 0, and o_pix_cnt and o_line_cnt SHALL be 0.
REQ-020 Reset asserted mid-frame SHALL abort immediately with no frame_done pulse; o_vs and o_de SHALL be 0 from the next clock.

Configuration
REQ-021 With macro VTG_EXT_TRIG_EN defined, the block SHALL add input i_frame_trig (1 bit, single-cycle pulse).
  - IDLE -> VSYNC and VFRONT -> VSYNC SHALL require a trigger latched since the last VSYNC entry, in addition to i_enable.
  - Without a latched trigger, VFRONT -> IDLE SHALL be taken.
  - Triggers arriving while the FSM is outside IDLE and VFRONT SHALL be latched, at most one.
REQ-022 Without VTG_EXT_TRIG_EN, the port SHALL be absent and the block SHALL free-run per REQ-009.

Structure
REQ-023 Package video_timing_pkg SHALL hold the FSM state typedef (vtg_state_t), the default timing constants and the pack ratio constant of 16.
REQ-024 The line/pixel counter pair SHALL be a sub-module, vtg_hv_counter, with outputs h_cnt, v_cnt and line_wrap; all FSM logic SHALL remain in the top level.

Verification
REQ-025 The bench SHALL use FRAME_WIDTH=16, H_BLANK=4, FRAME_HEIGHT=3, V_SYNC=1, V_BACK=2, V_FRONT=1 (H_TOTAL=20).
REQ-026 Scenario — basic frame: i_enable=1 held -> o_vs high for 20 clocks; 3 groups of 16 o_de clocks separated by 4; o_frame_done after 140 clocks; o_frame_cnt=1.
REQ-027 Scenario — disable: i_enable dropped during line 1 of ACTIVE -> the frame completes, o_frame_cnt=1, o_busy=0, and no further VS occurs.
REQ-028 Scenario — reset mid-frame: rd_rst pulsed during ACTIVE line 2 -> o_de=0 on the next clock, o_frame_cnt=0, no frame_done pulse.
REQ-029 Scenario — counter wrap: o_frame_cnt forced to 16'hFFFF, one frame run -> o_frame_cnt=0.
REQ-030 Scenario — external trigger (VTG_EXT_TRIG_EN defined): i_enable=1 with no trigger -> stays IDLE; one i_frame_trig -> exactly one frame, then IDLE.
REQ-031 Scenario — downstream integration: connected to the AXI read path with a 256-bit model, 640x512 -> 327,680 o_de clocks per frame and no FIFO underflow.
